// File: rtl/aes_frame_packer.sv
// Byte-stream to FRAME_W-bit frame packer feeding the AES mode core.
// Bytes pack MSB-first; short final frames are zero-padded.
module aes_frame_packer #(
  parameter int FRAME_W = 180
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [7:0]         s_data,
  input  logic               s_valid,
  input  logic               s_last,
  output logic               s_ready,
  output logic [FRAME_W-1:0] m_frame,
  output logic               m_valid,
  input  logic               m_ready,
  output logic [4:0]         m_nbytes,
  output logic               m_last,
  output logic [15:0]        frame_cnt
);

  localparam int NBEATS = (FRAME_W + 7) / 8;
  localparam int REM    = FRAME_W % 8;
  localparam int AW     = (REM == 0) ? FRAME_W : FRAME_W + 8 - REM;

  typedef enum logic {
    FILL,
    HOLD
  } state_t;

  state_t        state;
  state_t        state_nx;
  logic          take;
  logic          close;
  logic          hand;
  logic [4:0]    cnt;
  logic [AW-1:0] acc;
  logic [AW-1:0] merged;

  assign take  = s_valid && s_ready;
  assign close = take && (s_last || cnt == 5'(NBEATS - 1));
  assign hand  = m_valid && m_ready;

  // Byte-aligned scratch; bits below the frame fall off on close.
  assign merged = acc | ({s_data, {(AW-8){1'b0}}} >> {cnt, 3'b000});

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= FILL;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      FILL: if (close) state_nx = HOLD;
      HOLD: if (hand)  state_nx = FILL;
      default: state_nx = FILL;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      s_ready   <= 1'b0;
      cnt       <= '0;
      acc       <= '0;
      m_frame   <= '0;
      m_valid   <= 1'b0;
      m_nbytes  <= '0;
      m_last    <= 1'b0;
      frame_cnt <= '0;
    end else begin
      s_ready <= (state_nx == FILL);
      if (take) begin
        if (close) begin
          acc      <= '0;
          cnt      <= '0;
          m_frame  <= merged[AW-1 -: FRAME_W];
          m_nbytes <= cnt + 5'd1;
          m_last   <= s_last;
          m_valid  <= 1'b1;
        end else begin
          acc <= merged;
          cnt <= cnt + 5'd1;
        end
      end
      if (hand) begin
        m_valid   <= 1'b0;
        frame_cnt <= frame_cnt + 16'd1;
      end
    end
  end

endmodule

// File: doc/aes_frame_packer.md
Name: aes_frame_packer

Overview:
- Upstream feeder for the 180-bit AES mode core (CFB/OFB/CTR).
- Accepts a byte stream over a valid/ready handshake and assembles it MSB-first into FRAME_W-bit plaintext frames.
- Zero-pads short final frames.
- Presents each frame on a held output register with valid/ready, plus valid-byte count and last-of-message flag.

Parameters:
- FRAME_W, 180, frame width in bits.
- NBEATS = ceil(FRAME_W/8) = 23, derived (localparam): beats per full frame.
- REM = FRAME_W%8 = 4, derived (localparam): bits taken from the final beat; 0 means a full byte.

Ports:
- clk, input, 1: clock, rising edge.
- reset, input, 1: asynchronous, active-low reset.
- s_data, input, 8: input byte.
- s_valid, input, 1: s_data valid.
- s_last, input, 1: byte is the last of the message.
- s_ready, output, 1: packer can accept a byte.
- m_frame, output, FRAME_W: assembled plaintext frame.
- m_valid, output, 1: m_frame valid.
- m_ready, input, 1: consumer takes the frame.
- m_nbytes, output, 5: number of input bytes in the frame, 1..NBEATS.
- m_last, output, 1: frame was closed by s_last.
- frame_cnt, output, 16: frames delivered since reset; wraps 0xFFFF to 0.

Behaviour:
- Reset (reset=0, async) gives:
  - state=FILL, beat counter=0, accumulator=0
  - m_frame=0, m_valid=0, m_nbytes=0, m_last=0, frame_cnt=0
  - s_ready=0 while reset is asserted; 1 from the first clock edge after release.
- s_ready is registered, and equals (state==FILL).
- A byte is accepted when s_valid && s_ready.
- Packing: beat k (0-based) writes s_data into frame bits [FRAME_W-1-8k -: 8].
  - On beat NBEATS-1 with REM!=0, only s_data[7:8-REM] is used, written to frame[REM-1:0].
  - The low 8-REM bits of that beat are discarded.
- FILL state:
  - Each accepted byte increments the beat counter.
  - Frame closes when an accepted byte has s_last=1, or the counter reaches NBEATS-1.
  - On close (same edge):
    - m_frame = accumulator with the current byte merged, unwritten bits 0.
    - m_nbytes = beats including this one.
    - m_last = s_last.
    - m_valid = 1.
    - Accumulator and counter clear; state goes to HOLD; s_ready = 0.
- HOLD state:
  - m_frame, m_nbytes and m_last are stable while m_valid=1 && !m_ready.
  - On m_valid && m_ready: m_valid=0, frame_cnt+1, state goes to FILL.
  - s_ready returns to 1 on that same edge, so the next byte can be accepted in the cycle after the handshake.
- Latency: m_valid rises on the edge that accepts the closing byte. The frame is visible the cycle after that byte is presented.
- Throughput: max one frame per NBEATS+1 cycles.
- s_last on beat NBEATS-1 gives m_last=1 and m_nbytes=23.
- A 23-byte close without s_last gives m_last=0, and the message continues into the next frame from beat 0.
- s_valid while s_ready=0: the byte is not consumed. The source must hold it.
- m_ready while m_valid=0: ignored.
- Reset mid-frame: the partial frame is lost and the output clears immediately (async).
- s_data and s_last are don't-care when s_valid=0.

Test Plan:
- Full frame:
  - Stimulus: bytes f5 90 f3 d9 a7 eb 96 e1 e9 70 61 ad ac d4 72 e1 0d 08 4b 41 ce 40 3a, s_last on the 23rd, m_ready=1.
  - Required: m_frame=180'hf590f3d9a7eb96e1e97061adacd472e10d084b41ce403, m_nbytes=23, m_last=1, frame_cnt=1.
- Short frame:
  - Stimulus: bytes 11 22 33, s_last on 33.
  - Required: m_frame = 0x112233 in bits [179:156], all other bits 0; m_nbytes=3; m_last=1.
- Backpressure:
  - Stimulus: m_ready=0 for 10 cycles after a frame closes, with s_valid held at 1.
  - Required: s_ready=0, m_frame stable, no bytes consumed.
  - Then m_ready=1 for one cycle: frame_cnt increments and s_ready=1 on the next cycle.
- Multi-frame message:
  - Stimulus: 30 bytes 00..1d, s_last on 1d.
  - Required frame 1: bytes 00..16 (byte 0x16 contributes nibble 1), m_last=0, m_nbytes=23.
  - Required frame 2: bytes 17..1d in the top 56 bits, m_last=1, m_nbytes=7.
- Mid-frame reset:
  - Stimulus: 5 bytes, then reset low for 1 cycle, then 1 byte aa with s_last.
  - Required: m_frame[179:172]=aa, rest 0, m_nbytes=1, frame_cnt=1.
- Gapped input:
  - Stimulus: s_valid toggling randomly across a 23-byte message.
  - Required: m_frame identical to the ungapped result.
